// File: rtl/msg_stream_checker.sv
// Receive-side checker for the ASCII message generator stream.
// Aligns to the start of the selected message, checks every byte against
// an internal ROM and reports frame completions, mismatches and lock.
// Ports:
//   clk, reset            clock, async active-low reset
//   data_in[7:0], valid   received byte and its qualifier
//   select[1:0]           message choice (group = select[0]^select[1]: 0=A, 1=B)
//   locked                high after LOCK_FRAMES consecutive good frames
//   frame_ok, err         one-cycle registered pulses
//   char_idx[3:0]         index of next expected character (0 = hunting)
//   frame_count, err_count saturating event counters
module msg_stream_checker #(
    parameter int unsigned LOCK_FRAMES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       data_in,
    input  logic             valid,
    input  logic [1:0]       select,
    output logic             locked,
    output logic             frame_ok,
    output logic             err,
    output logic [3:0]       char_idx,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int unsigned RUN_W   = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_FRAMES);

    typedef enum logic {HUNT, TRACK} state_t;

    state_t           state;
    logic             grp_q;
    logic [RUN_W-1:0] run;

    // Message ROM: group 0 = "Guatemala", group 1 = 51 51 75 65 74 7A 61
    function automatic logic [7:0] rom_byte(input logic g, input logic [3:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (!g) begin
            case (idx)
                4'd0: b = 8'h47;
                4'd1: b = 8'h75;
                4'd2: b = 8'h61;
                4'd3: b = 8'h74;
                4'd4: b = 8'h65;
                4'd5: b = 8'h6D;
                4'd6: b = 8'h61;
                4'd7: b = 8'h6C;
                4'd8: b = 8'h61;
                default: b = 8'h00;
            endcase
        end else begin
            case (idx)
                4'd0: b = 8'h51;
                4'd1: b = 8'h51;
                4'd2: b = 8'h75;
                4'd3: b = 8'h65;
                4'd4: b = 8'h74;
                4'd5: b = 8'h7A;
                4'd6: b = 8'h61;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    logic       grp;
    logic       is_first;
    logic       is_cur;
    logic [3:0] last_idx;

    assign grp      = select[0] ^ select[1];
    assign is_first = (data_in == rom_byte(grp, 4'd0));
    assign is_cur   = (data_in == rom_byte(grp, char_idx));
    assign last_idx = grp ? 4'd6 : 4'd8;

    // Checker state machine, counters and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= HUNT;
            char_idx    <= 4'd0;
            locked      <= 1'b0;
            frame_ok    <= 1'b0;
            err         <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
            run         <= '0;
            grp_q       <= select[0] ^ select[1];
        end else begin
            grp_q    <= grp;
            frame_ok <= 1'b0;
            err      <= 1'b0;

            // Lock follows one cycle after the good-frame run saturates
            if (run == RUN_MAX) begin
                locked <= 1'b1;
            end

            if (grp_q != grp) begin
                // Group change: abort silently, byte is hunted in new message
                run      <= '0;
                locked   <= 1'b0;
                state    <= HUNT;
                char_idx <= 4'd0;
                if (valid && is_first) begin
                    state    <= TRACK;
                    char_idx <= 4'd1;
                end
            end else if (valid) begin
                if (state == HUNT) begin
                    if (is_first) begin
                        state    <= TRACK;
                        char_idx <= 4'd1;
                    end
                end else if (is_cur) begin
                    if (char_idx == last_idx) begin
                        frame_ok <= 1'b1;
                        state    <= HUNT;
                        char_idx <= 4'd0;
                        if (frame_count != '1) begin
                            frame_count <= frame_count + CNT_W'(1);
                        end
                        if (run != RUN_MAX) begin
                            run <= run + RUN_W'(1);
                        end
                    end else begin
                        char_idx <= char_idx + 4'd1;
                    end
                end else begin
                    // Mismatch: the offending byte may itself start a new frame
                    err    <= 1'b1;
                    locked <= 1'b0;
                    run    <= '0;
                    if (err_count != '1) begin
                        err_count <= err_count + CNT_W'(1);
                    end
                    if (is_first) begin
                        state    <= TRACK;
                        char_idx <= 4'd1;
                    end else begin
                        state    <= HUNT;
                        char_idx <= 4'd0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_msg_stream_checker.sv
// Scoreboard bench for msg_stream_checker: directed byte streams push the
// expected frame_ok/err events; a monitor pops and compares on each pulse.
module tb_msg_stream_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid;
    logic [1:0] select;
    logic       locked;
    logic       frame_ok;
    logic       err;
    logic [3:0] char_idx;
    logic [7:0] frame_count;
    logic [7:0] err_count;

    msg_stream_checker #(.LOCK_FRAMES(2), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .valid       (valid),
        .select      (select),
        .locked      (locked),
        .frame_ok    (frame_ok),
        .err         (err),
        .char_idx    (char_idx),
        .frame_count (frame_count),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  kind;   // {err, frame_ok}
        logic [7:0]  fc;
        logic [7:0]  ec;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] exp_fc = 0;
    logic [7:0] exp_ec = 0;

    logic [7:0] msg_a [9] = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65, 8'h6D, 8'h61, 8'h6C, 8'h61};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one valid byte; ek: 0 none, 1 frame_ok, 2 err
    task automatic send(input logic [7:0] d, input logic [1:0] ek);
        exp_t e;
        data_in = d;
        valid   = 1'b1;
        if (ek == 2'd1 && exp_fc != 8'hFF) exp_fc = exp_fc + 8'd1;
        if (ek == 2'd2 && exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
        if (ek != 2'd0) begin
            e.kind = ek;
            e.fc   = exp_fc;
            e.ec   = exp_ec;
            e.cyc  = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid   = 1'b0;
        data_in = 8'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_a();
        for (int i = 0; i < 9; i++) send(msg_a[i], (i == 8) ? 2'd1 : 2'd0);
    endtask

    initial begin
        // Monitor: compare every output pulse against the scoreboard head
        fork
            forever begin
                @(negedge clk);
                if (frame_ok || err) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event: frame_ok=%0b err=%0b at cycle %0d", frame_ok, err, cyc);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        if ({err, frame_ok} !== e.kind || frame_count !== e.fc ||
                            err_count !== e.ec || cyc !== e.cyc) begin
                            failures++;
                            $display("FAIL event: got kind=%0d fc=%0d ec=%0d cyc=%0d expected kind=%0d fc=%0d ec=%0d cyc=%0d",
                                     {err, frame_ok}, frame_count, err_count, cyc,
                                     e.kind, e.fc, e.ec, e.cyc);
                        end
                    end
                end
            end
        join_none

        // Reset with random activity on the inputs
        reset  = 1'b0;
        select = 2'b00;
        for (int i = 0; i < 5; i++) begin
            data_in = 8'($urandom);
            valid   = 1'($urandom);
            @(posedge clk);
            #1;
            chk("reset_outputs", {locked, frame_ok, err, char_idx, frame_count, err_count}, 32'd0);
        end
        reset = 1'b1;
        idle(3);
        chk("post_reset_outputs", {locked, frame_ok, err, char_idx, frame_count, err_count}, 32'd0);

        // Message A: three back-to-back frames, lock after two
        frame_a();
        chk("locked_after_f1", locked, 0);
        frame_a();
        chk("locked_at_f2_end", locked, 0);
        idle(1);
        chk("locked_after_f2", locked, 1);
        frame_a();
        chk("fc_after_f3", frame_count, 3);
        chk("ec_after_f3", err_count, 0);
        chk("locked_after_f3", locked, 1);

        // Corrupt index 4 of a locked frame
        for (int i = 0; i < 4; i++) send(msg_a[i], 2'd0);
        send(8'h00, 2'd2);
        chk("locked_after_err", locked, 0);
        chk("idx_after_err", char_idx, 0);
        for (int i = 5; i < 9; i++) send(msg_a[i], 2'd0);
        frame_a();
        chk("locked_one_good", locked, 0);
        frame_a();
        idle(1);
        chk("locked_relock", locked, 1);

        // Message B with a mismatch that restarts the frame
        select = 2'b01;
        idle(1);
        chk("locked_grp_change", locked, 0);
        send(8'h51, 2'd0);
        send(8'h51, 2'd0);
        send(8'h51, 2'd2);
        chk("idx_restart", char_idx, 1);
        send(8'h51, 2'd0);
        send(8'h75, 2'd0);
        send(8'h65, 2'd0);
        send(8'h74, 2'd0);
        send(8'h7A, 2'd0);
        send(8'h61, 2'd1);
        chk("idx_b_done", char_idx, 0);

        // valid gap mid-frame
        select = 2'b00;
        idle(1);
        for (int i = 0; i < 3; i++) send(msg_a[i], 2'd0);
        idle(3);
        chk("idx_in_gap", char_idx, 3);
        for (int i = 3; i < 9; i++) send(msg_a[i], (i == 8) ? 2'd1 : 2'd0);

        // Change within group A: no effect
        for (int i = 0; i < 4; i++) send(msg_a[i], 2'd0);
        select = 2'b11;
        for (int i = 4; i < 9; i++) send(msg_a[i], (i == 8) ? 2'd1 : 2'd0);
        idle(1);
        chk("locked_within_grp", locked, 1);

        // Change to group B mid-frame; the byte is hunted against B
        for (int i = 0; i < 3; i++) send(msg_a[i], 2'd0);
        select = 2'b01;
        send(8'h51, 2'd0);
        chk("idx_grp_abort", char_idx, 1);
        chk("locked_grp_abort", locked, 0);
        chk("ec_grp_abort", err_count, 2);
        send(8'h51, 2'd0);
        send(8'h75, 2'd0);
        send(8'h65, 2'd0);
        send(8'h74, 2'd0);
        send(8'h7A, 2'd0);
        send(8'h61, 2'd1);

        // Saturation of frame_count
        select = 2'b00;
        idle(1);
        for (int f = 0; f < 300; f++) frame_a();
        chk("fc_saturated", frame_count, 255);
        chk("ec_final", err_count, 2);
        frame_a();
        chk("fc_stays_sat", frame_count, 255);

        // Asynchronous reset mid-frame, away from any clock edge
        send(8'h47, 2'd0);
        send(8'h75, 2'd0);
        #2 reset = 1'b0;
        #1;
        chk("async_reset", {locked, char_idx, frame_count, err_count}, 32'd0);
        reset  = 1'b1;
        exp_fc = 0;
        exp_ec = 0;
        @(posedge clk);
        #1;
        idle(3);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
